// File: rtl/wide_add_sequencer.sv
// Word-serial wide adder/subtractor: one 32-bit carry-lookahead slice per cycle,
// with the carry chained through a register and results published on completion.
module wide_add_sequencer #(
  parameter int NWORDS = 4
) (
  input  logic                   Clk,
  input  logic                   Rst_N,
  input  logic                   Start,
  input  logic                   Sub,
  input  logic                   Abort,
  input  logic [32*NWORDS-1:0]   A_In,
  input  logic [32*NWORDS-1:0]   B_In,
  output logic                   Busy,
  output logic                   Done,
  output logic [32*NWORDS-1:0]   Sum,
  output logic                   C_Out,
  output logic                   Ovf
);

  localparam int W  = 32 * NWORDS;
  localparam int IW = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_sub;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  // Only the lower words are parked here; the top word goes straight to Sum.
  logic [W-33:0]   r_part;

  logic [31:0]     w_a_word;
  logic [31:0]     w_b_word;
  logic [33:0]     w_add;
  logic [W-1:0]    w_final;
  logic            w_last;

  // Returns {carry into bit 31, carry out, sum} for one 32-bit slice.
  function automatic logic [33:0] cla32(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    logic [31:0] p;
    logic [31:0] g;
    logic [32:0] c;
    p    = a ^ b;
    g    = a & b;
    c    = 33'd0;
    c[0] = cin;
    for (int i = 0; i < 32; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[31], c[32], p ^ c[31:0]};
  endfunction

  // Current word slice and its add result.
  always_comb begin
    w_a_word = r_a[r_idx*32 +: 32];
    w_b_word = r_b[r_idx*32 +: 32] ^ {32{r_sub}};
    w_add    = cla32(w_a_word, w_b_word, r_carry);
    w_final  = {w_add[31:0], r_part};
    w_last   = (r_idx == LAST);
  end

  // Sequencer state, operand latches, carry chain and published results.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_part  <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Sum     <= '0;
      C_Out   <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          Done <= 1'b0;
          if (Start) begin
            r_a     <= A_In;
            r_b     <= B_In;
            r_sub   <= Sub;
            r_idx   <= '0;
            r_carry <= Sub;
            r_state <= S_RUN;
            Busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            Busy    <= 1'b0;
          end
        end
        S_RUN: begin
          if (Abort) begin
            r_state <= S_IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b0;
          end else if (w_last) begin
            Sum     <= w_final;
            C_Out   <= w_add[32];
            Ovf     <= w_add[33] ^ w_add[32];
            r_state <= S_DONE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
          end else begin
            r_part[r_idx*32 +: 32] <= w_add[31:0];
            r_carry <= w_add[32];
            r_idx   <= r_idx + IW'(1);
            Busy    <= 1'b1;
            Done    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          Busy    <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer (NWORDS=4): arithmetic corners, timing,
// back-to-back, abort and mid-operation reset.
module tb_wide_add_sequencer;

  localparam int NW = 4;
  localparam int W  = 32 * NW;

  logic         Clk;
  logic         Rst_N;
  logic         Start;
  logic         Sub;
  logic         Abort;
  logic [W-1:0] A_In;
  logic [W-1:0] B_In;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         C_Out;
  logic         Ovf;

  int n_total = 0;
  int n_bad   = 0;
  int lat;
  int busy_n;
  int done_n;

  wide_add_sequencer #(.NWORDS(NW)) dut (
    .Clk(Clk), .Rst_N(Rst_N), .Start(Start), .Sub(Sub), .Abort(Abort),
    .A_In(A_In), .B_In(B_In), .Busy(Busy), .Done(Done),
    .Sum(Sum), .C_Out(C_Out), .Ovf(Ovf)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Drive a request at the current time; the caller owns edge alignment.
  task automatic kick(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    A_In  = a;
    B_In  = b;
    Sub   = s;
    Start = 1'b1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge Clk);
    kick(a, b, s);
    @(posedge Clk);
  endtask

  // Called just after the accepting edge; counts edges to Done and Busy cycles.
  // poke > 0 asserts a stray Start with junk operands in that RUN cycle.
  task automatic wait_done(input int poke, output int l, output int bn);
    bit found;
    found = 1'b0;
    l  = 0;
    bn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      Start = 1'b0;
      Abort = 1'b0;
      if (Done) begin
        found = 1'b1;
        break;
      end
      if (Busy) bn++;
      l++;
      if (l == poke) begin
        A_In  = {W{1'b1}};
        B_In  = {W{1'b1}};
        Sub   = ~Sub;
        Start = 1'b1;
      end
    end
    if (!found) l = 999;
  endtask

  // Abort in RUN cycle 'at' (1-based); expects no Done and unchanged outputs.
  task automatic abort_op(input int at, input logic [W-1:0] exp_sum, input logic exp_c,
                          input logic exp_v);
    start_op(128'd1, 128'd2, 1'b0);
    for (int i = 1; i <= at; i++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (i == at) Abort = 1'b1;
    end
    @(negedge Clk);
    Abort = 1'b0;
    check_val($sformatf("abort%0d_busy", at), {127'd0, Busy}, 128'd0);
    done_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (Done) done_n++;
      @(negedge Clk);
    end
    check_val($sformatf("abort%0d_nodone", at), W'(done_n), 128'd0);
    check_val($sformatf("abort%0d_sum", at), Sum, exp_sum);
    check_val($sformatf("abort%0d_cout", at), {127'd0, C_Out}, {127'd0, exp_c});
    check_val($sformatf("abort%0d_ovf", at), {127'd0, Ovf}, {127'd0, exp_v});
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] s, input logic c,
                              input logic v);
    check_val({tag, "_lat"}, W'(lat), 128'd4);
    check_val({tag, "_busy"}, W'(busy_n), 128'd4);
    check_val({tag, "_sum"}, Sum, s);
    check_val({tag, "_cout"}, {127'd0, C_Out}, {127'd0, c});
    check_val({tag, "_ovf"}, {127'd0, Ovf}, {127'd0, v});
  endtask

  initial begin
    Rst_N = 1'b0;
    Start = 1'b0;
    Sub   = 1'b0;
    Abort = 1'b0;
    A_In  = '0;
    B_In  = '0;
    #12;
    check_val("rst_outs", {Busy, Done, C_Out, Ovf, Sum[123:0]}, 128'd0);
    check_val("rst_sum", Sum, 128'd0);
    @(negedge Clk);
    Rst_N = 1'b1;

    // All ones + 1: full carry ripple across every word.
    start_op({W{1'b1}}, 128'd1, 1'b0);
    wait_done(0, lat, busy_n);
    check_result("t1", 128'd0, 1'b1, 1'b0);
    @(negedge Clk);
    check_val("t1_done_pulse", {126'd0, Done, Busy}, 128'd0);

    // 0 - 1: borrow through all words.
    start_op(128'd0, 128'd1, 1'b1);
    wait_done(0, lat, busy_n);
    check_result("t2a", {W{1'b1}}, 1'b0, 1'b0);

    // 5 - 5.
    start_op(128'd5, 128'd5, 1'b1);
    wait_done(0, lat, busy_n);
    check_result("t2b", 128'd0, 1'b1, 1'b0);

    // Max positive + 1 overflows; Abort held in IDLE must be ignored.
    @(negedge Clk);
    Abort = 1'b1;
    kick({1'b0, {127{1'b1}}}, 128'd1, 1'b0);
    @(posedge Clk);
    wait_done(0, lat, busy_n);
    check_result("t3", {1'b1, 127'd0}, 1'b0, 1'b1);

    // 3 + 4 with a stray Start mid-RUN, then back-to-back 2^64 - 1.
    start_op(128'd3, 128'd4, 1'b0);
    wait_done(2, lat, busy_n);
    check_result("b2b1", 128'd7, 1'b0, 1'b0);
    kick(128'h0000_0000_0000_0001_0000_0000_0000_0000, 128'd1, 1'b1);
    @(posedge Clk);
    wait_done(0, lat, busy_n);
    check_result("b2b2", 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

    // Abort in the third RUN cycle, then coinciding with the final word.
    abort_op(3, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    abort_op(4, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

    // Reset during the second RUN cycle, then a fresh operation.
    start_op(128'd9, 128'd9, 1'b0);
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    Rst_N = 1'b0;
    #1;
    check_val("mrst_flags", {124'd0, Busy, Done, C_Out, Ovf}, 128'd0);
    check_val("mrst_sum", Sum, 128'd0);
    @(negedge Clk);
    Rst_N = 1'b1;
    kick(128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0000,
         128'h0000_0001_0000_0000_0000_0001_0000_0000, 1'b0);
    @(posedge Clk);
    wait_done(0, lat, busy_n);
    check_result("post_rst", 128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
